// File: rtl/ff_cmd_arbiter.sv
// Round-robin command arbiter in front of a JK-style bit bank, with a registered acknowledge.
// Optional requester lock (FF_CMD_ARB_LOCK_EN) adds a_lock/b_lock and an UNLOCKED/LOCK_A/LOCK_B FSM.
module ff_cmd_arbiter #(
    parameter int IDX_W = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      a_valid,
    input  logic [IDX_W-1:0]          a_idx,
    input  logic [1:0]                a_op,
`ifdef FF_CMD_ARB_LOCK_EN
    input  logic                      a_lock,
`endif
    output logic                      a_ready,
    input  logic                      b_valid,
    input  logic [IDX_W-1:0]          b_idx,
    input  logic [1:0]                b_op,
`ifdef FF_CMD_ARB_LOCK_EN
    input  logic                      b_lock,
`endif
    output logic                      b_ready,
    output logic [(1 << IDX_W)-1:0]   q,
    output logic                      ack_valid,
    output logic                      ack_src,
    output logic [IDX_W-1:0]          ack_idx,
    output logic                      ack_q
);

    function automatic logic jk_next(input logic cur, input logic [1:0] op);
        case (op)
            2'b00:   return cur;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~cur;
        endcase
    endfunction

    // prio: 0 = A has priority, 1 = B has priority
    logic             prio;
    logic             accept;
    logic             sel_b;
    logic [IDX_W-1:0] cmd_idx;
    logic [1:0]       cmd_op;
    logic             new_bit;

`ifdef FF_CMD_ARB_LOCK_EN
    localparam logic [1:0] UNLOCKED = 2'b00;
    localparam logic [1:0] LOCK_A   = 2'b01;
    localparam logic [1:0] LOCK_B   = 2'b10;

    logic [1:0] lock_state;

    always_comb begin
        a_ready = a_valid && (!b_valid || !prio);
        b_ready = b_valid && (!a_valid || prio);
        if (lock_state == LOCK_A) begin
            a_ready = a_valid;
            b_ready = 1'b0;
        end else if (lock_state == LOCK_B) begin
            a_ready = 1'b0;
            b_ready = b_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_state <= UNLOCKED;
        end else begin
            case (lock_state)
                UNLOCKED: begin
                    if (a_ready && a_lock)
                        lock_state <= LOCK_A;
                    else if (b_ready && b_lock)
                        lock_state <= LOCK_B;
                end
                LOCK_A: if (a_ready && !a_lock) lock_state <= UNLOCKED;
                LOCK_B: if (b_ready && !b_lock) lock_state <= UNLOCKED;
                default: lock_state <= UNLOCKED;
            endcase
        end
    end
`else
    assign a_ready = a_valid && (!b_valid || !prio);
    assign b_ready = b_valid && (!a_valid || prio);
`endif

    // Grants are mutually exclusive, so b_ready alone selects the winning command
    assign accept  = a_ready | b_ready;
    assign sel_b   = b_ready;
    assign cmd_idx = sel_b ? b_idx : a_idx;
    assign cmd_op  = sel_b ? b_op  : a_op;
    assign new_bit = jk_next(q[cmd_idx], cmd_op);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q         <= '0;
            prio      <= 1'b0;
            ack_valid <= 1'b0;
            ack_src   <= 1'b0;
            ack_idx   <= '0;
            ack_q     <= 1'b0;
        end else begin
            ack_valid <= accept;
            if (accept) begin
                q[cmd_idx] <= new_bit;
                prio       <= ~sel_b;
                ack_src    <= sel_b;
                ack_idx    <= cmd_idx;
                ack_q      <= new_bit;
            end
        end
    end

endmodule

// File: doc/ff_cmd_arbiter.md
# ff_cmd_arbiter

Shares one bank of JK-style state bits between two command requesters. Each accepted command sets, clears, toggles or holds one addressed bit. The block sits in front of the flip-flop bank: it sequences all updates, arbitrates round-robin between requesters A and B, and returns a registered acknowledge carrying the bit's new value.

## Interface

Parameters:
- IDX_W, 3, index width; bank width WIDTH = 1 << IDX_W (8 by default)

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- a_valid  input  1  requester A command valid
- a_idx  input  IDX_W  requester A target bit
- a_op  input  2  requester A op {j,k}: 00 hold, 01 clear, 10 set, 11 toggle
- a_ready  output  1  requester A granted this cycle
- b_valid, b_idx, b_op, b_ready: same as A, for requester B
- q  output  WIDTH  bank state
- ack_valid  output  1  one-cycle pulse after each accepted command
- ack_src  output  1  source of acked command: 0 = A, 1 = B
- ack_idx  output  IDX_W  bit index of acked command
- ack_q  output  1  value of q[ack_idx] after the update

## Operation

- Accept rule: a command is accepted on a rising edge where valid && ready. At most one command is accepted per cycle.
- Grant (combinational from valid and state only; ready never depends on ready):
  - a_ready = a_valid && (!b_valid || prio == A)
  - b_ready = b_valid && (!a_valid || prio == B)
- Priority pointer prio:
  - After every accept, prio points to the requester that was not granted.
  - prio updates on uncontested grants as well.
  - Reset value: A.
- Bit update for q[idx] on accept, JK semantics:
  - 00: unchanged
  - 01: 0
  - 10: 1
  - 11: inverted
  - All other bits of q are unchanged.
- Hold (00) is still accepted and still acknowledged.
- Requesters must hold valid, idx and op stable until ready. Dropping valid before ready withdraws the request without effect.
- Both requesters may target the same index in the same cycle. Only the granted one executes. The other executes on a later grant against the already-updated bit.

## Timing

- Reset values:
  - q = 0
  - ack_valid = 0, ack_src = 0, ack_idx = 0, ack_q = 0
  - prio = A
  - lock state UNLOCKED (when compiled in)
- Reset asserted mid-operation clears everything immediately. Any command presented in that cycle is lost and not acknowledged.
- Update latency: q changes on the same edge that accepts the command.
- Acknowledge latency:
  - ack_* is registered on the accept edge and is visible for exactly the following cycle.
  - With back-to-back accepts, ack_valid stays high continuously and each cycle's ack_* describes the previous cycle's command.
- Throughput: one command per cycle sustained. With both requesters continuously valid, grants alternate A, B, A, B…

## Configuration

- Macro: FF_CMD_ARB_LOCK_EN.
- Defined:
  - Adds inputs a_lock and b_lock (1 bit each, sampled with the command).
  - Adds a state machine with states UNLOCKED, LOCK_A and LOCK_B.
- Transitions:
  - UNLOCKED → LOCK_A on accept of an A command with a_lock = 1; same for B → LOCK_B.
  - LOCK_A → UNLOCKED on accept of an A command with a_lock = 0; same for B.
- While in LOCK_A:
  - b_ready = 0.
  - a_ready = a_valid.
  - prio still updates per the normal rule, so B wins the first contest after unlock.
- Not defined: no lock ports, no state machine; pure round-robin as above.

## Test plan

- Reset, then single ops from A:
  - set idx 2, then toggle idx 2, then clear idx 5 → q = 0x04, then 0x00, then 0x00.
  - ack_q = 1, 0, 0, each one cycle after its accept; ack_src = 0.
- Contention:
  - A and B both continuously valid; A sets idx 0, B sets idx 1.
  - Expect: first grant A (prio reset = A), second grant B, q = 0x03 after 2 edges.
  - a_ready/b_ready alternate every cycle.
- Same-index collision:
  - A toggle idx 7 and B toggle idx 7 presented together from reset.
  - Expect: A executes → q[7] = 1; B executes next cycle → q[7] = 0.
  - Two acks with ack_q 1 then 0.
- Hold op: B op 00 on idx 3 with q = 0xFF → q stays 0xFF; ack_valid = 1, ack_q = 1, ack_src = 1.
- Async reset mid-stream:
  - After q = 0x5A, assert reset between clock edges.
  - Expect: q = 0, ack_valid = 0 immediately, without waiting for a clock edge.
  - The first grant after release goes to A.
- FF_CMD_ARB_LOCK_EN:
  - A issues set idx 0 with a_lock = 1, while B is continuously valid with set idx 1.
  - A then issues 3 more commands: lock=1, lock=1, lock=0.
  - Expect: b_ready = 0 for all 4 A accepts; B is granted on the cycle after A's unlocking accept.
